timer_arbiter: RTL
==================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the delay counter.
REQ-002 Parameter CNT_W, default 3, width of the delay counter and threshold.
REQ-003 Port clock  input  1  sole clock; all state changes on posedge.
REQ-004 Port clear_n  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  N_REQ  per-requester level request; held high until done or abandoned.
REQ-006 Port thresh  input  CNT_W  delay length, sampled at grant.
REQ-007 Port grant  output  N_REQ  one-hot owner of the counter; all-zero when idle.
REQ-008 Port busy  output  1  high whenever grant is non-zero.
REQ-009 Port done  output  N_REQ  one-cycle pulse to the owner when its delay expires.
REQ-010 Port count  output  CNT_W  current counter value, for debug.

Function
REQ-011 FSM states SHALL be IDLE, CLEAR, COUNT, DONE.
REQ-012 IDLE: if any req high, SHALL select the winner round-robin starting at pointer ptr, latch thresh into thresh_q, set grant, and go to CLEAR; else stay.
REQ-013 CLEAR: SHALL hold one cycle, force counter to 0, and go to COUNT.
REQ-014 COUNT: counter SHALL increment by 1 per cycle, saturating at 2^CNT_W-1; when count == thresh_q, SHALL go to DONE next cycle.
REQ-015 COUNT SHALL therefore last exactly thresh_q+1 cycles; thresh_q=0 gives a one-cycle COUNT.
REQ-016 DONE: SHALL assert done[owner] for exactly one cycle, then go to IDLE with grant cleared.
REQ-017 Grant-to-done latency SHALL be thresh_q+3 cycles, counting from the first grant cycle (CLEAR 1, COUNT thresh_q+1, DONE 1).
REQ-018 On leaving CLEAR, COUNT or DONE, ptr SHALL become (owner+1) mod N_REQ.
REQ-019 If the owner's req drops during CLEAR or COUNT, SHALL abort to IDLE next cycle with no done pulse and ptr advanced.
REQ-020 A req drop in DONE SHALL NOT suppress the done pulse.
REQ-021 Changes to thresh while granted SHALL have no effect.
REQ-022 Requests from non-owners SHALL be ignored until IDLE; earliest re-grant SHALL be the cycle after DONE or abort.
REQ-023 grant SHALL be one-hot or zero at all times; done SHALL be zero except on the owner bit in DONE.
REQ-024 Simultaneous requests SHALL be served in ring order from ptr, so no requester waits more than N_REQ-1 grants.

Reset
REQ-025 clear_n low SHALL immediately force state IDLE, counter 0, ptr 0, thresh_q 0, and grant, busy, done, count all 0.
REQ-026 Reset mid-COUNT SHALL abort silently with no done pulse.
REQ-027 After clear_n rises, the first IDLE evaluation SHALL be the next posedge.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, CLEAR, COUNT, DONE) and the default CNT_W/N_REQ constants.
REQ-029 The counter SHALL be a sub-module sat_counter (sync clear, enable, saturating increment, async active-low reset); the FSM, round-robin pointer and threshold compare stay in timer_arbiter.

Verification
REQ-030 req=0001, thresh=3 -> grant=0001 for 6 cycles, done=0001 pulses on the 6th, count runs 0,1,2,3.
REQ-031 req=1111 held, thresh=0 -> grants in order 0001,0010,0100,1000,0001, each 3 cycles long, one done per grant.
REQ-032 req=0101 after a grant to bit 0 -> next grant 0100, then 0001; no starvation.
REQ-033 Owner drops req at count=2, thresh=5 -> IDLE next cycle, no done, ptr advanced.
REQ-034 clear_n pulsed low at count=4 -> all outputs 0 at once; after release, req=0010 is granted with ptr starting at 0.
REQ-035 thresh=7 -> count reaches 7 with no wrap, done after 10 cycles; thresh changed to 1 mid-count is ignored.

Source files
------------

// File: rtl/timer_arbiter_pkg.sv
// Shared FSM encoding and default sizing for the timer arbiter.
package timer_arbiter_pkg;

   localparam int DEF_N_REQ = 4;
   localparam int DEF_CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/timer_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module sat_counter
   import timer_arbiter_pkg::*;
#(
   parameter int W = DEF_CNT_W
) (
   input  logic         clock,
   input  logic         clear_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && (count != {W{1'b1}}))
         count <= count + W'(1);
   end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter lending one shared delay counter to N_REQ requesters;
// the owner gets a done pulse thresh+3 cycles after its grant.
module timer_arbiter
   import timer_arbiter_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic [N_REQ-1:0] req,
   input  logic [CNT_W-1:0] thresh,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic [N_REQ-1:0] done,
   output logic [CNT_W-1:0] count
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t           state, state_nx;
   logic [IDX_W-1:0] ptr, owner, win, cand, owner_inc;
   logic [CNT_W-1:0] thresh_q;
   logic             any_req, found, own_req, at_thresh;
   logic             cnt_clr, cnt_en;

   assign any_req   = |req;
   assign own_req   = req[owner];
   assign at_thresh = (count == thresh_q);
   assign owner_inc = IDX_W'((int'(owner) + 1) % N_REQ);

   // First requester at or after ptr, walking the ring.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = IDX_W'((int'(ptr) + k) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = CLEAR;
         CLEAR:   state_nx = own_req ? COUNT : IDLE;
         COUNT:   if (!own_req)      state_nx = IDLE;
                  else if (at_thresh) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Owner and threshold are frozen for the whole grant; ptr moves past the
   // owner on every exit from a granted state, including aborts.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         owner    <= '0;
         ptr      <= '0;
         thresh_q <= '0;
      end else if (state == IDLE) begin
         if (any_req) begin
            owner    <= win;
            thresh_q <= thresh;
         end
      end else if (state_nx != state) begin
         ptr <= owner_inc;
      end
   end

   always_comb begin
      grant   = '0;
      done    = '0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state)
         CLEAR: begin
            grant[owner] = 1'b1;
            cnt_clr      = 1'b1;
         end
         COUNT: begin
            grant[owner] = 1'b1;
            cnt_en       = 1'b1;
         end
         DONE: begin
            grant[owner] = 1'b1;
            done[owner]  = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy = |grant;

   sat_counter #(.W(CNT_W)) u_cnt (
      .clock   (clock),
      .clear_n (clear_n),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .count   (count)
   );

endmodule
